sseg_scan_mux: RTL and testbench

Time-multiplexed scan driver for a 4-digit common-anode seven-segment display. It consumes four active-low `gfedcba` segment patterns, one per digit, from upstream per-digit hex decoders. It drives the shared segment, decimal-point and anode lines with a programmable refresh rate and anti-ghosting dead time. Input patterns are double-buffered so a new display value changes only at a frame boundary, never mid-scan.

---
 rtl/sseg_pkg.sv | 33 +++
 rtl/sseg_scan_mux_if.sv | 33 +++
 rtl/refresh_timer.sv | 39 +++
 rtl/sseg_scan_mux.sv | 122 ++++++++++++
 tb/tb_sseg_scan_mux.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment display path
// (scan driver and the upstream per-digit hex decoders).
package sseg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // Phase within one digit slot: anodes held off, or the selected anode driven.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } slot_state_t;

  // One complete display image: segment patterns, decimal points, digit enables.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][6:0] seg;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      en;
  } disp_buf_t;

  localparam disp_buf_t BUF_RESET = '{
    seg: {NUM_DIGITS{SEG_BLANK}},
    dp:  '0,
    en:  '0
  };

  // Active-low anode vector selecting a single digit.
  function automatic logic [NUM_DIGITS-1:0] anode_select(input logic [1:0] idx);
    return AN_OFF ^ (4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// Bundle between the display-value producer and the scan driver, plus the
// driver's display-side outputs and its slot-phase debug view.
interface sseg_scan_mux_if;
  import sseg_pkg::*;

  // load is a one-cycle strobe with no back-pressure: it is always accepted,
  // and a later load before the frame boundary replaces the earlier one.
  // pending is high while an accepted image waits for the next frame boundary.
  logic [6:0]          seg0;
  logic [6:0]          seg1;
  logic [6:0]          seg2;
  logic [6:0]          seg3;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                load;
  logic                pending;
  logic                frame_start;
  logic [6:0]          seg;
  logic                dp;
  logic [NUM_DIGITS-1:0] an;
  slot_state_t         slot_state;

  modport master (
    output seg0, seg1, seg2, seg3, dp_in, digit_en, load,
    input  pending, frame_start, seg, dp, an, slot_state
  );

  modport slave (
    input  seg0, seg1, seg2, seg3, dp_in, digit_en, load,
    output pending, frame_start, seg, dp, an, slot_state
  );

endinterface

// File: rtl/refresh_timer.sv
// Digit-slot timer: counts REFRESH_DIV cycles per slot and flags the
// leading dead-time window in which all anodes stay off.
module refresh_timer #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic slot_end,
  output logic in_dead
);

  localparam int             CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  TERM = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign slot_end = (cnt == TERM);

  // With no dead time the comparison would be constant, so tie it off.
  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt < CW'(DEAD_CYCLES));
    end
  endgenerate

endmodule

// File: rtl/sseg_scan_mux.sv
// Four-digit common-anode scan driver with a frame-synchronous double buffer
// and anti-ghosting dead time at the start of every digit slot.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  sseg_scan_mux_if.slave    bus
);

  logic        slot_end;
  logic        in_dead;
  logic [1:0]  idx;
  logic        boundary;

  disp_buf_t   in_buf;
  disp_buf_t   pend_buf;
  disp_buf_t   act_buf;
  logic        pending_q;

  slot_state_t state;
  slot_state_t next_state;

  logic [6:0]            seg_d;
  logic [6:0]            seg_q;
  logic                  dp_d;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_d;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_start_q;

  refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .slot_end (slot_end),
    .in_dead  (in_dead)
  );

  assign in_buf   = {bus.seg3, bus.seg2, bus.seg1, bus.seg0, bus.dp_in, bus.digit_en};
  assign boundary = slot_end && (idx == 2'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (slot_end) begin
      idx <= idx + 2'd1;
    end
  end

  // A load that lands on the boundary bypasses the pending stage entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_buf  <= BUF_RESET;
      act_buf   <= BUF_RESET;
      pending_q <= 1'b0;
    end else if (boundary) begin
      if (bus.load) begin
        act_buf <= in_buf;
      end else if (pending_q) begin
        act_buf <= pend_buf;
      end
      pending_q <= 1'b0;
    end else if (bus.load) begin
      pend_buf  <= in_buf;
      pending_q <= 1'b1;
    end
  end

  // state tracks the slot phase of the cycle currently on the output pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = DRIVE;
    seg_d      = SEG_BLANK;
    dp_d       = 1'b1;
    an_d       = AN_OFF;
    if (in_dead) begin
      next_state = BLANK;
    end
    if (act_buf.en[idx]) begin
      seg_d = act_buf.seg[idx];
      dp_d  = ~act_buf.dp[idx];
      if (next_state == DRIVE) begin
        an_d = anode_select(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= boundary;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending_q;
  assign bus.slot_state  = state;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Self-checking bench for sseg_scan_mux: directed scenarios plus random loads,
// compared cycle by cycle against a time-indexed reference model.
module tb_sseg_scan_mux;
  import sseg_pkg::*;

  localparam int RD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = 4 * RD;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sseg_scan_mux_if bus ();

  sseg_scan_mux #(
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // stimulus image presented on the inputs
  logic [6:0] in_seg [4];
  logic [3:0] in_dp;
  logic [3:0] in_en;

  // reference model: cycles since reset, displayed image, waiting image
  int         t;
  logic [6:0] m_seg [4];
  logic [3:0] m_dp;
  logic [3:0] m_en;
  logic [6:0] p_seg [4];
  logic [3:0] p_dp;
  logic [3:0] p_en;
  logic       m_pend;

  // {slot_state, an, seg, dp, pending, frame_start}
  logic [14:0] exp_q [$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (model t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_seg[k] = 7'h7F;
      p_seg[k] = 7'h7F;
    end
    m_dp = '0; m_en = '0; p_dp = '0; p_en = '0;
    m_pend = 1'b0;
    t = 0;
  endtask

  // One clock: drive inputs, predict the post-edge outputs, advance, compare.
  task automatic tick(input logic rst_v, input logic ld);
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fs;
    logic        e_st;
    logic [14:0] e;
    logic [14:0] got;
    int c;
    int d;
    reset        = rst_v;
    bus.load     = ld;
    bus.seg0     = in_seg[0];
    bus.seg1     = in_seg[1];
    bus.seg2     = in_seg[2];
    bus.seg3     = in_seg[3];
    bus.dp_in    = in_dp;
    bus.digit_en = in_en;
    if (rst_v) begin
      model_clear();
      e = {1'b0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
    end else begin
      c     = t % RD;
      d     = (t / RD) % 4;
      e_fs  = ((t % FRAME) == FRAME - 1);
      e_st  = (c >= DC);
      e_an  = (e_st && m_en[d]) ? (4'hF ^ (4'(1) << d)) : 4'hF;
      e_seg = m_en[d] ? m_seg[d] : 7'h7F;
      e_dp  = m_en[d] ? ~m_dp[d] : 1'b1;
      if (e_fs) begin
        if (ld) begin
          for (int k = 0; k < 4; k++) m_seg[k] = in_seg[k];
          m_dp = in_dp; m_en = in_en;
        end else if (m_pend) begin
          for (int k = 0; k < 4; k++) m_seg[k] = p_seg[k];
          m_dp = p_dp; m_en = p_en;
        end
        m_pend = 1'b0;
      end else if (ld) begin
        for (int k = 0; k < 4; k++) p_seg[k] = in_seg[k];
        p_dp = in_dp; p_en = in_en;
        m_pend = 1'b1;
      end
      e = {e_st, e_an, e_seg, e_dp, m_pend, e_fs};
      t++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("slot_state",  32'(bus.slot_state), 32'(got[14]));
    check("an",          32'(bus.an),         32'(got[13:10]));
    check("seg",         32'(bus.seg),        32'(got[9:3]));
    check("dp",          32'(bus.dp),         32'(got[2]));
    check("pending",     32'(bus.pending),    32'(got[1]));
    check("frame_start", 32'(bus.frame_start), 32'(got[0]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  // t always advances, so this waits at most one frame
  task automatic run_until(input int phase);
    for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) in_seg[k] = 7'h7F;
    in_dp = '0;
    in_en = '0;
    bus.load = 1'b0;
    model_clear();

    // reset hold, then idle: blank display, frame_start every frame
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    run(64);

    // basic scan
    in_seg[0] = 7'b1000000; in_seg[1] = 7'b0100100;
    in_seg[2] = 7'b0110000; in_seg[3] = 7'b0011001;
    in_en = 4'b1111; in_dp = 4'b0010;
    run(5);
    tick(1'b0, 1'b1);
    run(72);

    // digit enable
    in_en = 4'b0101;
    tick(1'b0, 1'b1);
    run(64);

    // last load wins
    in_en = 4'b1111;
    run_until(2);
    in_seg[0] = 7'b1111001;
    tick(1'b0, 1'b1);
    run(5);
    in_seg[0] = 7'b0010010;
    tick(1'b0, 1'b1);
    run(60);

    // load coincident with the frame boundary
    run_until(FRAME - 1);
    in_seg[0] = 7'b0001000; in_dp = 4'b1000;
    tick(1'b0, 1'b1);
    run(40);

    // reset in the middle of digit 2 with a load waiting
    run_until(3);
    in_seg[1] = 7'b0000011;
    tick(1'b0, 1'b1);
    run_until(2 * RD + 4);
    tick(1'b1, 1'b0);
    run(40);

    // random loads and occasional resets
    for (int i = 0; i < 900; i++) begin
      logic ld;
      logic rs;
      ld = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 349) == 0);
      if (ld) begin
        for (int k = 0; k < 4; k++) in_seg[k] = 7'($urandom);
        in_dp = 4'($urandom);
        in_en = 4'($urandom);
      end
      tick(rs, ld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
